// File: rtl/counter_driver.sv
`default_nettype none
// ============================================================================
// Module   : counter_driver
// Brief    : Host-side initiator sequencing init/start/read strobes for the
//            counter accelerator; optional stats via COUNTER_DRIVER_STATS_EN.
// Revision : 1.0
// ============================================================================
module counter_driver #(
    parameter int xLen      = 64,
    parameter int PULSE_LEN = 2,
    parameter int TIMEOUT   = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_op,
    input  logic [xLen-1:0] cmd_data,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [xLen-1:0] resp_data,
    output logic            resp_err,
    output logic            busy,
    output logic            ctr_init,
    output logic [xLen-1:0] ctr_init_val,
    output logic            ctr_start,
    output logic            ctr_return_current_count,
    input  logic [xLen-1:0] ctr_current_count,
    input  logic            ctr_count_valid
`ifdef COUNTER_DRIVER_STATS_EN
    ,
    output logic [15:0]     stat_reads,
    output logic [15:0]     stat_timeouts
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STROBE = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    localparam logic [1:0] c_OP_INIT   = 2'b00;
    localparam logic [1:0] c_OP_START  = 2'b01;
    localparam logic [1:0] c_OP_READ   = 2'b10;
    localparam logic [3:0] c_PULSE_LAST = 4'(PULSE_LEN - 1);
    localparam logic [7:0] c_TIMER_LAST = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic            started_q, started_d;
    logic [3:0]      pulse_q, pulse_d;
    logic [7:0]      timer_q, timer_d;
    logic            cv_q;
    logic [xLen-1:0] init_val_q, init_val_d;
    logic [xLen-1:0] resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic w_accept;
    logic w_reject;
    logic w_cv_rise;
    logic w_read_ok;
    logic w_read_to;

    assign w_accept  = cmd_valid && (state_q == S_IDLE);
    assign w_reject  = (cmd_op == 2'b11)
                    || ((cmd_op == c_OP_INIT || cmd_op == c_OP_START) && started_q)
                    || ((cmd_op == c_OP_READ) && !started_q);
    // cv_q tracks the input every cycle, so a level already high on WAIT entry is not an edge
    assign w_cv_rise = ctr_count_valid && !cv_q;
    assign w_read_ok = (state_q == S_WAIT) && w_cv_rise;
    assign w_read_to = (state_q == S_WAIT) && !w_cv_rise && (timer_q == c_TIMER_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            started_q   <= 1'b0;
            pulse_q     <= 4'd0;
            timer_q     <= 8'd0;
            cv_q        <= 1'b0;
            init_val_q  <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            started_q   <= started_d;
            pulse_q     <= pulse_d;
            timer_q     <= timer_d;
            cv_q        <= ctr_count_valid;
            init_val_q  <= init_val_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        started_d   = started_q;
        pulse_d     = pulse_q;
        timer_d     = timer_q;
        init_val_d  = init_val_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d    = cmd_op;
                    pulse_d = 4'd0;
                    timer_d = 8'd0;
                    if (w_reject) begin
                        state_d     = S_RESP;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                    end else begin
                        state_d     = S_STROBE;
                        resp_err_d  = 1'b0;
                        resp_data_d = (cmd_op == c_OP_INIT) ? cmd_data : '0;
                        if (cmd_op == c_OP_INIT) begin
                            init_val_d = cmd_data;
                        end
                    end
                end
            end
            S_STROBE: begin
                if (op_q == c_OP_READ) begin
                    state_d = S_WAIT;
                    timer_d = 8'd0;
                end else if (pulse_q == c_PULSE_LAST) begin
                    state_d = S_RESP;
                    if (op_q == c_OP_START) begin
                        started_d = 1'b1;
                    end
                end else begin
                    pulse_d = pulse_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (w_read_ok) begin
                    state_d     = S_RESP;
                    resp_data_d = ctr_current_count;
                    resp_err_d  = 1'b0;
                end else if (w_read_to) begin
                    state_d     = S_RESP;
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cmd_ready                = (state_q == S_IDLE);
    assign busy                     = (state_q != S_IDLE);
    assign resp_valid               = (state_q == S_RESP);
    assign resp_data                = resp_data_q;
    assign resp_err                 = resp_err_q;
    assign ctr_init_val             = init_val_q;
    assign ctr_init                 = (state_q == S_STROBE) && (op_q == c_OP_INIT);
    assign ctr_start                = (state_q == S_STROBE) && (op_q == c_OP_START);
    assign ctr_return_current_count = (state_q == S_STROBE) && (op_q == c_OP_READ);

`ifdef COUNTER_DRIVER_STATS_EN
    logic [15:0] stat_reads_q;
    logic [15:0] stat_timeouts_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_reads_q    <= 16'd0;
            stat_timeouts_q <= 16'd0;
        end else begin
            if (w_read_ok && (stat_reads_q != 16'hFFFF)) begin
                stat_reads_q <= stat_reads_q + 16'd1;
            end
            if (w_read_to && (stat_timeouts_q != 16'hFFFF)) begin
                stat_timeouts_q <= stat_timeouts_q + 16'd1;
            end
        end
    end

    assign stat_reads    = stat_reads_q;
    assign stat_timeouts = stat_timeouts_q;
`endif

endmodule
`default_nettype wire
